sync_sram_param: RTL and testbench

SYNC_SRAM_PARAM -- requirements
Module: sync_sram_param

---
 rtl/sync_sram_param.sv | 149 ++++++++++++++
 tb/tb_sync_sram_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_sram_param.sv
// sync_sram_param: single-port synchronous SRAM with a Start-strobe handshake,
// fixed access latency and a bidirectional data bus. Optional byte parity via SYNC_SRAM_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a Start rising edge
// ACC    | access timer counting down; commit/latch at terminal count
// DONE   | MemDone pulse; read word driven on DataIO
// HOLD   | read word still driven, MemDone low; back to IDLE next
module sync_sram_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int ACCESS = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic                Write,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W/8-1:0] ByteEn,
  inout  wire  [DATA_W-1:0]   DataIO,
  output logic                MemDone,
  output logic                Busy,
  output logic                ParityErr
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_start_prev;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_req;
  logic w_take;
  logic w_commit;
  logic w_rd_phase;

  assign w_req      = Start & ~r_start_prev;
  assign w_take     = Rst_n && (r_state == S_IDLE) && w_req;
  // Gating with Rst_n keeps a reset at the terminal-count edge from committing the write.
  assign w_commit   = Rst_n && (r_state == S_ACC) && (r_cnt == 4'd0);
  assign w_rd_phase = ~r_we && ((r_state == S_DONE) || (r_state == S_HOLD));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_start_prev <= 1'b1;
    end else begin
      r_start_prev <= Start;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_ACC;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_ACC: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_HOLD;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_take) begin
      r_we    <= Write;
      r_addr  <= Address;
      r_be    <= ByteEn;
      r_wdata <= DataIO;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_commit) begin
      if (r_we) begin
        for (int b = 0; b < NB; b++) begin
          if (r_be[b]) begin
            r_mem[r_addr][b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

`ifdef SYNC_SRAM_PARITY_EN
  logic [NB-1:0]     r_par [DEPTH];
  logic              r_perr;
  logic [NB-1:0]     w_wr_par;
  logic [NB-1:0]     w_rd_par;
  logic [DATA_W-1:0] w_rd_word;

  assign w_rd_word = r_mem[r_addr];

  // Even parity: stored bit makes each byte plus its parity bit an even population.
  always_comb begin
    w_wr_par = '0;
    w_rd_par = '0;
    for (int b = 0; b < NB; b++) begin
      w_wr_par[b] = ^r_wdata[b*8 +: 8];
      w_rd_par[b] = ^w_rd_word[b*8 +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (w_commit) begin
      if (r_we) begin
        for (int b = 0; b < NB; b++) begin
          if (r_be[b]) begin
            r_par[r_addr][b] <= w_wr_par[b];
          end
        end
      end else begin
        r_perr <= |(w_rd_par ^ r_par[r_addr]);
      end
    end
  end

  assign ParityErr = r_perr & w_rd_phase;
`else
  assign ParityErr = 1'b0;
`endif

  assign MemDone = (r_state == S_DONE);
  assign Busy    = (r_state != S_IDLE);
  assign DataIO  = w_rd_phase ? r_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sync_sram_param.sv
// Directed bench for sync_sram_param: default instance (ACCESS=4, 32-bit) plus a
// wide, single-cycle-access instance (ACCESS=1, DATA_W=64, ADDR_W=10).
module tb_sync_sram_param;

  localparam int ACC1 = 4;
  localparam int ACC2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, wr, oe;
  logic [7:0]  addr;
  logic [3:0]  be;
  logic [31:0] drv;
  wire  [31:0] dq;
  logic        done, busy, perr;
  assign dq = oe ? drv : 32'bz;

  logic        start2, wr2, oe2;
  logic [9:0]  addr2;
  logic [7:0]  be2;
  logic [63:0] drv2;
  wire  [63:0] dq2;
  logic        done2, busy2, perr2;
  assign dq2 = oe2 ? drv2 : 64'bz;

  int n_tests = 0;
  int n_fail  = 0;

  sync_sram_param #(.DATA_W(32), .ADDR_W(8), .ACCESS(ACC1)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Write(wr), .Address(addr),
    .ByteEn(be), .DataIO(dq), .MemDone(done), .Busy(busy), .ParityErr(perr)
  );

  sync_sram_param #(.DATA_W(64), .ADDR_W(10), .ACCESS(ACC2)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .Start(start2), .Write(wr2), .Address(addr2),
    .ByteEn(be2), .DataIO(dq2), .MemDone(done2), .Busy(busy2), .ParityErr(perr2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the default instance, checking handshake timing and read data.
  task automatic req1(input string tag, input logic w, input logic [7:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_pe);
    int lat;
    start = 1'b1; wr = w; addr = a; be = b; drv = d; oe = w;
    tick();
    start = 1'b0; oe = 1'b0;
    check({tag, "_busy_acc"}, 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(ACC1 + 1));
    check({tag, "_perr_done"}, 64'(perr), 64'(exp_pe));
    if (!w) check({tag, "_data_done"}, 64'(dq), 64'(exp_rd));
    tick();
    check({tag, "_done_hold"}, 64'(done), 64'd0);
    check({tag, "_busy_hold"}, 64'(busy), 64'd1);
    check({tag, "_perr_hold"}, 64'(perr), 64'(exp_pe));
    if (!w) check({tag, "_data_hold"}, 64'(dq), 64'(exp_rd));
    tick();
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic req2(input string tag, input logic w, input logic [9:0] a, input logic [7:0] b,
                      input logic [63:0] d, input logic [63:0] exp_rd);
    int lat;
    start2 = 1'b1; wr2 = w; addr2 = a; be2 = b; drv2 = d; oe2 = w;
    tick();
    start2 = 1'b0; oe2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(ACC2 + 1));
    if (!w) check({tag, "_data_done"}, dq2, exp_rd);
    tick();
    check({tag, "_done_hold"}, 64'(done2), 64'd0);
    if (!w) check({tag, "_data_hold"}, dq2, exp_rd);
    tick();
    check({tag, "_busy_idle"}, 64'(busy2), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; wr = 1'b0; addr = '0; be = '0; drv = '0; oe = 1'b0;
    start2 = 1'b0; wr2 = 1'b0; addr2 = '0; be2 = '0; drv2 = '0; oe2 = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_perr", 64'(perr), 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    rst_n = 1'b1;
    tick();

    req1("wr0", 1'b1, 8'd0, 4'hF, 32'h87888001, 32'h0, 1'b0);
    req1("rd0", 1'b0, 8'd0, 4'h0, 32'h0, 32'h87888001, 1'b0);

    req1("wr129_all", 1'b1, 8'd129, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0);
    req1("wr129_be5", 1'b1, 8'd129, 4'b0101, 32'h00000000, 32'h0, 1'b0);
    req1("rd129", 0, 8'd129, 4'h0, 32'h0, 32'hFF00FF00, 1'b0);
    req1("wr129_be0", 1'b1, 8'd129, 4'h0, 32'h12345678, 32'h0, 1'b0);
    req1("rd129_be0", 1'b0, 8'd129, 4'h0, 32'h0, 32'hFF00FF00, 1'b0);

    // Bus must be released in IDLE: the bench's own pattern and its inverse read back intact.
    oe = 1'b1; drv = 32'hA5C30F96;
    #1 check("idle_z_pat", 64'(dq), 64'hA5C30F96);
    drv = 32'h5A3CF069;
    #1 check("idle_z_inv", 64'(dq), 64'h5A3CF069);
    oe = 1'b0;
    tick();

    // Start held high for 20 cycles.
    start = 1'b1; wr = 1'b0; addr = 8'd0; be = 4'h0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    repeat (8) begin
      tick();
      if (done) pulses++;
    end
    check("held_start_pulses", 64'(pulses), 64'd1);

    // Second edge while busy is dropped, not queued.
    start = 1'b1; addr = 8'd0; wr = 1'b0;
    tick();
    start = 1'b0;
    pulses = done ? 1 : 0;
    tick();
    if (done) pulses++;
    start = 1'b1;
    tick();
    if (done) pulses++;
    start = 1'b0;
    repeat (14) begin
      tick();
      if (done) pulses++;
    end
    check("busy_edge_pulses", 64'(pulses), 64'd1);
    check("busy_edge_idle", 64'(busy), 64'd0);

    // Reset on the second ACC cycle aborts the write.
    req1("wr131_prior", 1'b1, 8'd131, 4'hF, 32'hAAAA5555, 32'h0, 1'b0);
    start = 1'b1; wr = 1'b1; addr = 8'd131; be = 4'hF; drv = 32'h00000100; oe = 1'b1;
    tick();
    start = 1'b0; oe = 1'b0;
    tick();
    rst_n = 1'b0;
    pulses = 0;
    tick();
    check("abort2_busy", 64'(busy), 64'd0);
    if (done) pulses++;
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (done) pulses++;
    end
    check("abort2_no_done", 64'(pulses), 64'd0);
    req1("rd131", 1'b0, 8'd131, 4'h0, 32'h0, 32'hAAAA5555, 1'b0);

    // Reset landing on the terminal-count edge must also block the commit.
    req1("wr132_prior", 1'b1, 8'd132, 4'hF, 32'h13572468, 32'h0, 1'b0);
    start = 1'b1; wr = 1'b1; addr = 8'd132; be = 4'hF; drv = 32'hDEADBEEF; oe = 1'b1;
    tick();
    start = 1'b0; oe = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("abort_tc_busy", 64'(busy), 64'd0);
    check("abort_tc_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();
    req1("rd132", 1'b0, 8'd132, 4'h0, 32'h0, 32'h13572468, 1'b0);

    // Start already high when reset releases is not a request.
    rst_n = 1'b0; start = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("start_high_at_release", 64'(busy), 64'd0);
    start = 1'b0;
    tick();

`ifdef SYNC_SRAM_PARITY_EN
    req1("wr136", 1'b1, 8'd136, 4'hF, 32'h11223344, 32'h0, 1'b0);
    req1("wr137", 1'b1, 8'd137, 4'hF, 32'h55667788, 32'h0, 1'b0);
    dut.r_mem[136][0] = ~dut.r_mem[136][0];
    req1("rd136_flip", 1'b0, 8'd136, 4'h0, 32'h0, 32'h11223345, 1'b1);
    req1("rd137_clean", 1'b0, 8'd137, 4'h0, 32'h0, 32'h55667788, 1'b0);
`endif

    req2("w2_1023", 1'b1, 10'd1023, 8'hFF, 64'h0123456789ABCDEF, 64'h0);
    req2("r2_1023", 1'b0, 10'd1023, 8'h00, 64'h0, 64'h0123456789ABCDEF);
    oe2 = 1'b1; drv2 = 64'hF0E1D2C3B4A59687;
    #1 check("idle_z2_pat", dq2, 64'hF0E1D2C3B4A59687);
    drv2 = 64'h0F1E2D3C4B5A6978;
    #1 check("idle_z2_inv", dq2, 64'h0F1E2D3C4B5A6978);
    oe2 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
